// File: rtl/adc_sample_averager.sv
// Per-channel ADC sample averager: accumulates 2^AVG_LOG2 samples per channel
// and queues {channel, average} results in a small FIFO with a ready/valid output.
module adc_sample_averager #(
    parameter int AVG_LOG2   = 3,
    parameter int CHANNELS   = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        modular_adc_0_response_valid,
    input  logic [4:0]  modular_adc_0_response_channel,
    input  logic [11:0] modular_adc_0_response_data,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic [4:0]  avg_channel,
    output logic [11:0] avg_data,
    output logic [7:0]  drop_count,
    output logic [7:0]  bad_ch_count
);

    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [5:0]       CH_LIM   = 6'(CHANNELS);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
        return DATA_W'(s >> AVG_LOG2);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reset asserts asynchronously; sample acceptance waits for a synchronised release.
    logic [1:0] rst_sync;
    logic       run_en;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync <= 2'b00;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run_en = rst_sync[1];

    logic [ACC_W-1:0] acc [CHANNELS];
    logic [CNT_W-1:0] cnt [CHANNELS];

    logic              vld_p0;
    logic              ch_ok_p0;
    logic              last_p0;
    logic              push_p0;
    logic              bad_p0;
    logic [ACC_W-1:0]  acc_sel_p0;
    logic [CNT_W-1:0]  cnt_sel_p0;
    logic [ACC_W-1:0]  sum_p0;
    logic [DATA_W-1:0] result_p0;

    always_comb begin
        acc_sel_p0 = '0;
        cnt_sel_p0 = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (modular_adc_0_response_channel == 5'(c)) begin
                acc_sel_p0 = acc[c];
                cnt_sel_p0 = cnt[c];
            end
        end
    end

    assign vld_p0    = run_en & modular_adc_0_response_valid;
    assign ch_ok_p0  = {1'b0, modular_adc_0_response_channel} < CH_LIM;
    assign sum_p0    = acc_sel_p0 + ACC_W'(modular_adc_0_response_data);
    assign last_p0   = (cnt_sel_p0 == CNT_LAST);
    assign push_p0   = vld_p0 & ch_ok_p0 & last_p0;
    assign bad_p0    = vld_p0 & ~ch_ok_p0;
    assign result_p0 = avg_trunc(sum_p0);

    // Stage p0 -> accumulator state
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (vld_p0 && ch_ok_p0 && (modular_adc_0_response_channel == 5'(c))) begin
                    if (last_p0) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum_p0;
                        cnt[c] <= cnt[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    logic [4:0]        mem_ch   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              pop;
    logic              do_push;
    logic              drop;

    assign full    = (occ == OCC_FULL);
    assign pop     = avg_valid & avg_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_p0 & (~full | pop);
    assign drop    = push_p0 & full & ~pop;

    always_ff @(posedge clk_clk) begin
        if (do_push) begin
            mem_ch[wr_ptr]   <= modular_adc_0_response_channel;
            mem_data[wr_ptr] <= result_p0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            drop_count   <= '0;
            bad_ch_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (drop)   drop_count   <= sat_inc(drop_count);
            if (bad_p0) bad_ch_count <= sat_inc(bad_ch_count);
        end
    end

    // Head fields are masked so an empty or freshly reset FIFO presents zeros.
    assign avg_valid   = (occ != '0);
    assign avg_channel = avg_valid ? mem_ch[rd_ptr]   : '0;
    assign avg_data    = avg_valid ? mem_data[rd_ptr] : '0;

endmodule
